encoder_8to3_latched: RTL and testbench

- Inverse of the team's 3-to-8 LED decoder: takes 8 raw one-hot-ish input lines (switches/buttons) and returns a 3-bit binary code.
- Synchronises and debounces the lines, then priority-encodes them (highest index wins).
- Presents the code on a valid/ready handshake, one report per press-release cycle.
- Sits between board input pins and any consumer that drives the decoder or the display logic.

---
 rtl/encoder_pkg.sv | 58 +++++
 rtl/encoder_8to3_latched_debouncer.sv | 73 +++++++
 rtl/encoder_8to3_latched.sv | 100 ++++++++++
 tb/tb_encoder_8to3_latched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// -----------------------------------------------------------------------------
// encoder_pkg
//   Shared definitions for the 8-to-3 latched encoder:
//     - FSM state encoding for the report handshake
//     - packed report record (code + multi_hot)
//     - prio8()       : index of the highest set bit of an 8-bit vector
//     - multi_hot8()  : true when more than one bit of the vector is set
//     - make_report() : bundles both of the above into one report record
//   The helper functions are kept here so that decoder-side benches and
//   other consumers can share the exact same encode rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package encoder_pkg;

   // FSM states, kept as plain 2-bit constants for compatibility with older
   // blocks that compare state codes numerically.
   localparam logic [1:0] ST_IDLE         = 2'd0;
   localparam logic [1:0] ST_REPORT       = 2'd1;
   localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;

   localparam int unsigned LINES  = 8;
   localparam int unsigned CODE_W = 3;

   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic              multi_hot;
   } report_t;

   // Highest set bit wins. Scanning upward lets later (higher) hits
   // overwrite earlier ones. An all-zero vector yields 0, but callers only
   // invoke this with a nonzero vector.
   function automatic logic [CODE_W-1:0] prio8(input logic [LINES-1:0] v);
      logic [CODE_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < LINES; i++) begin
         if (v[i]) begin
            idx = CODE_W'(i);
         end
      end
      return idx;
   endfunction

   // Clearing the lowest set bit leaves something behind only when at least
   // two bits were set, which is exactly popcount(v) > 1.
   function automatic logic multi_hot8(input logic [LINES-1:0] v);
      logic [LINES-1:0] low_cleared;
      low_cleared = v & (v - LINES'(1));
      return (low_cleared != '0);
   endfunction

   function automatic report_t make_report(input logic [LINES-1:0] v);
      report_t r;
      r.code      = prio8(v);
      r.multi_hot = multi_hot8(v);
      return r;
   endfunction

endpackage

// File: rtl/encoder_8to3_latched_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//   Brings WIDTH asynchronous lines into the clk domain and only accepts a
//   new vector after it has stayed unchanged for DEBOUNCE_CYCLES cycles.
//
//   Ports
//     clk      in   1      system clock, rising edge
//     rst      in   1      synchronous active-high reset, clears all state
//     raw      in   WIDTH  asynchronous input lines
//     db       out  WIDTH  debounced vector
//
//   Timing: a stable change on raw reaches db SYNC_STAGES+DEBOUNCE_CYCLES
//   edges after the first edge that samples it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module input_debouncer #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] db
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // sync_p0 is the metastability-capture stage; the last element is the
   // only one the rest of the logic may look at.
   logic [WIDTH-1:0] sync_p0 [SYNC_STAGES];
   logic [WIDTH-1:0] sync_out;
   logic [WIDTH-1:0] cand_p1;
   logic [CNT_W-1:0] cnt_p1;

   // Stage 0: synchroniser chain
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_p0[s] <= '0;
         end
      end else begin
         sync_p0[0] <= raw;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_p0[s] <= sync_p0[s-1];
         end
      end
   end

   assign sync_out = sync_p0[SYNC_STAGES-1];

   // Stage 1: candidate tracking and stability counter.
   // Any difference between the synchronised lines and the candidate restarts
   // the count, so a glitch shorter than DEBOUNCE_CYCLES never reaches db.
   // Once the count reaches its last value it parks there, which keeps db
   // loading the same candidate every cycle without wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         cand_p1 <= '0;
         cnt_p1  <= '0;
         db      <= '0;
      end else if (sync_out != cand_p1) begin
         cand_p1 <= sync_out;
         cnt_p1  <= '0;
      end else if (cnt_p1 == CNT_LAST) begin
         db <= cand_p1;
      end else begin
         cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
   end

endmodule

// File: rtl/encoder_8to3_latched.sv
// -----------------------------------------------------------------------------
// encoder_8to3_latched
//   Debounced 8-to-3 priority encoder with a valid/ready report interface.
//   One report is issued per press/release cycle of the input lines: the code
//   is captured when the debounced vector first becomes nonzero, held until
//   the consumer accepts it, and no further report is made until every line
//   has been released.
//
//   Ports
//     clk         in   1  system clock, rising edge
//     rst         in   1  synchronous active-high reset, clears all state
//     in_lines    in   8  raw asynchronous lines, bit i maps to code i
//     code_ready  in   1  consumer accepts the report when code_valid=1
//     code        out  3  highest set debounced line at capture time
//     code_valid  out  1  a report is pending acceptance
//     multi_hot   out  1  more than one line was set at capture time
//     any_active  out  1  registered (debounced vector != 0)
//
//   code and multi_hot keep their last values after acceptance; consumers
//   must qualify them with code_valid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module encoder_8to3_latched
   import encoder_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_lines,
   input  logic       code_ready,
   output logic [2:0] code,
   output logic       code_valid,
   output logic       multi_hot,
   output logic       any_active
);

   logic [7:0] db;
   logic [1:0] state;
   report_t    rpt;

   input_debouncer #(
      .WIDTH           (8),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debouncer (
      .clk (clk),
      .rst (rst),
      .raw (in_lines),
      .db  (db)
   );

   assign rpt = make_report(db);

   // Stage 2: report FSM and handshake.
   // REPORT ignores db entirely, so a release before acceptance cannot
   // cancel or alter a pending report. WAIT_RELEASE blocks re-reporting
   // until the debounced vector is fully clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         code       <= '0;
         multi_hot  <= 1'b0;
         code_valid <= 1'b0;
         any_active <= 1'b0;
      end else begin
         any_active <= (db != '0);
         case (state)
            ST_IDLE: begin
               if (db != '0) begin
                  code       <= rpt.code;
                  multi_hot  <= rpt.multi_hot;
                  code_valid <= 1'b1;
                  state      <= ST_REPORT;
               end
            end
            ST_REPORT: begin
               if (code_valid && code_ready) begin
                  code_valid <= 1'b0;
                  state      <= ST_WAIT_RELEASE;
               end
            end
            ST_WAIT_RELEASE: begin
               if (db == '0) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               // Unreachable encoding: recover to a clean idle.
               code_valid <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_encoder_8to3_latched.sv
`timescale 1ns/1ps
module tb_encoder_8to3_latched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_lines = 8'h00;
   logic       code_ready = 1'b0;
   logic [2:0] code;
   logic       code_valid;
   logic       multi_hot;
   logic       any_active;

   int n_cmp = 0;
   int n_bad = 0;

   // expected reports, {code, multi_hot}, pushed by stimulus, popped by monitor
   logic [3:0] exp_q [$];

   encoder_8to3_latched dut (
      .clk        (clk),
      .rst        (rst),
      .in_lines   (in_lines),
      .code_ready (code_ready),
      .code       (code),
      .code_valid (code_valid),
      .multi_hot  (multi_hot),
      .any_active (any_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: each new report presented (rising code_valid) is compared with
   // the oldest expected entry.
   logic cv_prev = 1'b0;
   always @(negedge clk) begin
      if (code_valid && !cv_prev) begin
         if (exp_q.size() == 0) begin
            check("unexpected_report", {28'd0, code, multi_hot}, 32'hFFFF_FFFF);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            check("report_code", {29'd0, code}, {29'd0, e[3:1]});
            check("report_multi_hot", {31'd0, multi_hot}, {31'd0, e[0]});
         end
      end
      cv_prev = code_valid;
   end

   // advance n rising edges, then settle just after the edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, input int budget);
      int k;
      k = 0;
      while (!code_valid && k < budget) begin
         step(1);
         k++;
      end
      if (!code_valid) check({name, "_timeout"}, {31'd0, code_valid}, 32'd1);
   endtask

   task automatic accept(input string name);
      code_ready = 1'b1;
      step(1);
      code_ready = 1'b0;
      check({name, "_valid_drop"}, {31'd0, code_valid}, 32'd0);
   endtask

   logic [7:0] onehot;
   logic [7:0] decoded;

   initial begin
      // ---------------- reset ----------------
      step(3);
      rst = 1'b0;
      check("rst_code_valid", {31'd0, code_valid}, 32'd0);
      check("rst_code", {29'd0, code}, 32'd0);
      check("rst_multi_hot", {31'd0, multi_hot}, 32'd0);
      check("rst_any_active", {31'd0, any_active}, 32'd0);
      step(2);

      // ---------------- single press 8'h04, latency ----------------
      // First sampling edge is edge 1; valid appears after edge 8 (7 later).
      in_lines = 8'h04;
      exp_q.push_back({3'd2, 1'b0});
      step(7);
      check("lat_not_yet", {31'd0, code_valid}, 32'd0);
      step(1);
      check("lat_valid", {31'd0, code_valid}, 32'd1);
      check("lat_any_active", {31'd0, any_active}, 32'd1);
      step(20);
      check("held_valid", {31'd0, code_valid}, 32'd1);
      check("held_code", {29'd0, code}, 32'd2);
      accept("p04");
      in_lines = 8'h00;
      step(10);

      // ---------------- multi-hot 8'h81 ----------------
      in_lines = 8'h81;
      exp_q.push_back({3'd7, 1'b1});
      wait_valid("p81", 20);
      accept("p81");
      check("p81_code_kept", {29'd0, code}, 32'd7);
      check("p81_mh_kept", {31'd0, multi_hot}, 32'd1);
      in_lines = 8'h01;      // partial release: no new report allowed
      step(15);
      check("p01_no_report", {31'd0, code_valid}, 32'd0);
      check("p01_active", {31'd0, any_active}, 32'd1);
      in_lines = 8'h00;
      step(7);               // db clears after edge 7
      check("rel_active_hold", {31'd0, any_active}, 32'd1);
      step(1);
      check("rel_active_fall", {31'd0, any_active}, 32'd0);
      step(5);

      // ---------------- glitch: 3-cycle pulse ----------------
      in_lines = 8'h10;
      step(3);
      in_lines = 8'h00;
      for (int i = 0; i < 15; i++) begin
         check("glitch_valid", {31'd0, code_valid}, 32'd0);
         check("glitch_active", {31'd0, any_active}, 32'd0);
         step(1);
      end

      // ---------------- release before acceptance ----------------
      in_lines = 8'h08;
      exp_q.push_back({3'd3, 1'b0});
      wait_valid("p08", 20);
      in_lines = 8'h00;
      step(20);
      check("p08_still_valid", {31'd0, code_valid}, 32'd1);
      check("p08_code", {29'd0, code}, 32'd3);
      check("p08_active_gone", {31'd0, any_active}, 32'd0);
      accept("p08");
      step(2);
      // IDLE must have been reached: a new press reports again
      in_lines = 8'h02;
      exp_q.push_back({3'd1, 1'b0});
      wait_valid("p02", 20);
      accept("p02");
      in_lines = 8'h00;
      step(10);

      // ---------------- reset during REPORT ----------------
      in_lines = 8'h40;
      exp_q.push_back({3'd6, 1'b0});
      wait_valid("p40", 20);
      check("p40_code", {29'd0, code}, 32'd6);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("mid_rst_valid", {31'd0, code_valid}, 32'd0);
      check("mid_rst_code", {29'd0, code}, 32'd0);
      check("mid_rst_mh", {31'd0, multi_hot}, 32'd0);
      check("mid_rst_active", {31'd0, any_active}, 32'd0);
      exp_q.push_back({3'd6, 1'b0});
      step(7);
      check("post_rst_not_yet", {31'd0, code_valid}, 32'd0);
      step(1);
      check("post_rst_valid", {31'd0, code_valid}, 32'd1);
      accept("p40b");
      in_lines = 8'h00;
      step(10);

      // ---------------- single-bit sweep through a 3-to-8 decoder ----------------
      for (int i = 0; i < 8; i++) begin
         onehot = 8'h01 << i;
         in_lines = onehot;
         exp_q.push_back({3'(i), 1'b0});
         wait_valid("sweep", 20);
         decoded = 8'h01 << code;
         check("sweep_decode", {24'd0, decoded}, {24'd0, onehot});
         accept("sweep");
         in_lines = 8'h00;
         step(10);
         check("sweep_released", {31'd0, any_active}, 32'd0);
      end

      step(2);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
